hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV64 core.
- Produces the stall, write-enable and flush controls consumed by the PC, IF/ID, ID/EX and EX/MEM pipeline registers. Its flush output drives the ID/EX register's flush input.
- Handles load-use bubbles, taken-branch squashes and multi-cycle data-memory waits through a small FSM.
- Keeps performance counters and a sticky memory-timeout flag.

Parameters:
- FLUSH_DEPTH, 1, number of cycles IF/ID and ID/EX are squashed after a taken branch (1..3).
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before mem_timeout is set (1..65535).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ID_Rs1  in  5  rs1 of the instruction in ID.
- ID_Rs2  in  5  rs2 of the instruction in ID.
- ID_UsesRs2  in  1  the ID instruction reads rs2 (R, S and B formats).
- EX_Rd  in  5  destination register of the instruction in EX.
- EX_MemRead  in  1  the instruction in EX is a load.
- EX_BranchTaken  in  1  branch resolved taken in EX this cycle.
- MEM_Req  in  1  the instruction in MEM accesses data memory.
- MEM_Ready  in  1  data memory completes the access this cycle.
- PC_Write  out  1  PC update enable.
- IFID_Write  out  1  IF/ID load enable.
- IFID_Flush  out  1  IF/ID squash.
- IDEX_Flush  out  1  ID/EX squash; zeroes all ID/EX fields at the next edge.
- Pipe_Freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- mem_timeout  out  1  sticky error flag.
- stall_cycles  out  CNT_W  count of load-use plus memory-wait cycles.
- flush_events  out  CNT_W  count of taken-branch squashes.

Behaviour:
- Reset values (asynchronous): state=RUN, branch_pend=0, flush_cnt=0, wait_cnt=0, mem_timeout=0, both counters=0. Control outputs then decode to PC_Write=1, IFID_Write=1 and all flush/freeze outputs=0.
- Control outputs are combinational decodes of state and inputs. All consumers sample them at the rising edge.
- Load-use hazard (lu) = EX_MemRead && EX_Rd!=0 && (EX_Rd==ID_Rs1 || (ID_UsesRs2 && EX_Rd==ID_Rs2)).
- State RUN, checked in priority order:
  1. MEM_Req && !MEM_Ready: Pipe_Freeze=1, PC_Write=0, IFID_Write=0, no flushes. Next state is MEM_WAIT. If EX_BranchTaken, latch branch_pend=1.
  2. EX_BranchTaken: IFID_Flush=1, IDEX_Flush=1. flush_events+1. If FLUSH_DEPTH>1, next state is BR_FLUSH with flush_cnt=FLUSH_DEPTH-1. lu is ignored because the ID instruction is being squashed.
  3. lu: PC_Write=0, IFID_Write=0, IDEX_Flush=1 (one bubble). stall_cycles+1. State stays RUN.
  4. Otherwise all enables are 1 and all flush/freeze outputs are 0.
- State BR_FLUSH: IFID_Flush=1, IDEX_Flush=1, PC_Write=1. flush_cnt decrements each cycle; return to RUN when it reaches 0. A memory wait arriving here takes priority as in RUN, and the remaining flush_cnt is preserved. A new EX_BranchTaken cannot occur because EX holds a bubble; if asserted anyway, it is ignored.
- State MEM_WAIT: Pipe_Freeze=1, PC_Write=0, IFID_Write=0. stall_cycles+1 and wait_cnt+1 per cycle.
  - When wait_cnt reaches MEM_TIMEOUT, set mem_timeout=1 (cleared only by reset) and keep waiting.
  - When MEM_Ready=1: release the freeze that cycle and clear wait_cnt.
    - If branch_pend: next state is BR_FLUSH (or a single RUN-cycle flush when FLUSH_DEPTH=1), issue flushes on the following cycle, increment flush_events, clear branch_pend.
    - If flush_cnt was nonzero: resume BR_FLUSH.
    - Else: return to RUN.
- Counters wrap modulo 2^CNT_W with no saturation.
- Reset asserted mid-operation returns to RUN immediately. Pending branches and partial counts are discarded.

Decomposition:
- Shared package core_pkg:
  - state enum: RUN, BR_FLUSH, MEM_WAIT.
  - REG_X0 constant = 5'd0.
  - FLUSH_DEPTH default.
- One sub-module, hazard_lu_detect: the combinational load-use comparator, reusable by the forwarding unit.

Test Plan:
- Load x5, then add x6,x5,x7 in ID (EX_Rd=5, ID_Rs1=5, EX_MemRead=1) -> one cycle with PC_Write=0, IFID_Write=0, IDEX_Flush=1; stall_cycles=1.
- Load to x0 with ID_Rs1=0 -> no stall; all enables 1.
- EX_BranchTaken=1 with FLUSH_DEPTH=2 -> IFID_Flush=1 and IDEX_Flush=1 for exactly 2 cycles; flush_events=1.
- MEM_Req=1 with MEM_Ready low for 4 cycles -> Pipe_Freeze=1 for 4 cycles, released in the ready cycle; stall_cycles=4.
- Branch taken in the same cycle as a memory wait begins, ready after 3 cycles -> no flush during the wait; flushes start the cycle after the freeze is released; flush_events=1.
- MEM_TIMEOUT=8, ready never asserted -> mem_timeout rises on the 8th wait cycle and stays high. Reset asserted mid-wait -> state RUN, mem_timeout=0, counters=0 at once.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// core_pkg : shared pipeline-control types and constants
// Rev 1.0
// ============================================================================
package core_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      BR_FLUSH = 2'd1,
      MEM_WAIT = 2'd2
   } hz_state_t;

   localparam logic [4:0] REG_X0          = 5'd0;
   localparam int         FLUSH_DEPTH_DEF = 1;

endpackage : core_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_if : pipeline status in / pipeline-register controls out
// Rev 1.0
// ============================================================================
interface hazard_ctrl_if;

   logic [4:0] ID_Rs1;
   logic [4:0] ID_Rs2;
   logic       ID_UsesRs2;
   logic [4:0] EX_Rd;
   logic       EX_MemRead;
   logic       EX_BranchTaken;
   logic       MEM_Req;
   logic       MEM_Ready;

   logic       PC_Write;
   logic       IFID_Write;
   logic       IFID_Flush;
   logic       IDEX_Flush;
   logic       Pipe_Freeze;

   modport master (
      output ID_Rs1, ID_Rs2, ID_UsesRs2, EX_Rd, EX_MemRead, EX_BranchTaken,
             MEM_Req, MEM_Ready,
      input  PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze
   );

   modport slave (
      input  ID_Rs1, ID_Rs2, ID_UsesRs2, EX_Rd, EX_MemRead, EX_BranchTaken,
             MEM_Req, MEM_Ready,
      output PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze
   );

endinterface : hazard_ctrl_if
`default_nettype wire

// File: rtl/hazard_lu_detect.sv
`default_nettype none
// ============================================================================
// hazard_lu_detect : combinational load-use comparator (EX load vs ID sources)
// Rev 1.0
// ============================================================================
module hazard_lu_detect
   import core_pkg::*;
(
   input  logic [4:0] ex_rd,
   input  logic       ex_mem_read,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs2,
   output logic       load_use
);

   // x0 is never a real dependency, so a load targeting it cannot stall.
   assign load_use = ex_mem_read && (ex_rd != REG_X0) &&
                     ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

endmodule : hazard_lu_detect
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : stall/flush/freeze controller with perf counters and timeout
// Rev 1.0
// ============================================================================
module hazard_ctrl
   import core_pkg::*;
#(
   parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   hazard_ctrl_if.slave     hz,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam logic [1:0]  C_FLUSH_DEPTH = 2'(FLUSH_DEPTH);
   localparam logic [15:0] C_MEM_TIMEOUT = 16'(MEM_TIMEOUT);

   hz_state_t        r_state;
   logic             r_branch_pend;
   logic [1:0]       r_flush_cnt;
   logic [15:0]      r_wait_cnt;
   logic             r_mem_timeout;
   logic [CNT_W-1:0] r_stall_cycles;
   logic [CNT_W-1:0] r_flush_events;

   logic             w_lu;
   logic             w_mem_stall;
   logic [15:0]      w_wait_inc;

   hazard_lu_detect u_lu_detect (
      .ex_rd       (hz.EX_Rd),
      .ex_mem_read (hz.EX_MemRead),
      .id_rs1      (hz.ID_Rs1),
      .id_rs2      (hz.ID_Rs2),
      .id_uses_rs2 (hz.ID_UsesRs2),
      .load_use    (w_lu)
   );

   assign w_mem_stall = hz.MEM_Req && !hz.MEM_Ready;
   // Saturate so a very long wait cannot wrap and re-trigger the threshold.
   assign w_wait_inc  = (r_wait_cnt == C_MEM_TIMEOUT) ? r_wait_cnt : r_wait_cnt + 16'd1;

   always_comb begin
      hz.PC_Write    = 1'b1;
      hz.IFID_Write  = 1'b1;
      hz.IFID_Flush  = 1'b0;
      hz.IDEX_Flush  = 1'b0;
      hz.Pipe_Freeze = 1'b0;
      unique case (r_state)
         RUN: begin
            if (w_mem_stall) begin
               hz.Pipe_Freeze = 1'b1;
               hz.PC_Write    = 1'b0;
               hz.IFID_Write  = 1'b0;
            end else if (hz.EX_BranchTaken) begin
               hz.IFID_Flush  = 1'b1;
               hz.IDEX_Flush  = 1'b1;
            end else if (w_lu) begin
               hz.PC_Write    = 1'b0;
               hz.IFID_Write  = 1'b0;
               hz.IDEX_Flush  = 1'b1;
            end
         end
         BR_FLUSH: begin
            if (w_mem_stall) begin
               hz.Pipe_Freeze = 1'b1;
               hz.PC_Write    = 1'b0;
               hz.IFID_Write  = 1'b0;
            end else begin
               hz.IFID_Flush  = 1'b1;
               hz.IDEX_Flush  = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (!hz.MEM_Ready) begin
               hz.Pipe_Freeze = 1'b1;
               hz.PC_Write    = 1'b0;
               hz.IFID_Write  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= RUN;
         r_branch_pend  <= 1'b0;
         r_flush_cnt    <= 2'd0;
         r_wait_cnt     <= 16'd0;
         r_mem_timeout  <= 1'b0;
         r_stall_cycles <= '0;
         r_flush_events <= '0;
      end else begin
         unique case (r_state)
            RUN: begin
               if (w_mem_stall) begin
                  r_state <= MEM_WAIT;
                  if (hz.EX_BranchTaken) r_branch_pend <= 1'b1;
               end else if (hz.EX_BranchTaken) begin
                  r_flush_events <= r_flush_events + CNT_W'(1);
                  if (FLUSH_DEPTH > 1) begin
                     r_state     <= BR_FLUSH;
                     r_flush_cnt <= C_FLUSH_DEPTH - 2'd1;
                  end
               end else if (w_lu) begin
                  r_stall_cycles <= r_stall_cycles + CNT_W'(1);
               end
            end
            BR_FLUSH: begin
               // A memory wait here parks the remaining flush count untouched.
               if (w_mem_stall) begin
                  r_state <= MEM_WAIT;
               end else if (r_flush_cnt <= 2'd1) begin
                  r_flush_cnt <= 2'd0;
                  r_state     <= RUN;
               end else begin
                  r_flush_cnt <= r_flush_cnt - 2'd1;
               end
            end
            MEM_WAIT: begin
               r_stall_cycles <= r_stall_cycles + CNT_W'(1);
               if (hz.MEM_Ready) begin
                  r_wait_cnt <= 16'd0;
                  if (r_branch_pend) begin
                     // Full flush window runs after release; a depth of one is a single flush cycle.
                     r_branch_pend  <= 1'b0;
                     r_flush_events <= r_flush_events + CNT_W'(1);
                     r_flush_cnt    <= C_FLUSH_DEPTH;
                     r_state        <= BR_FLUSH;
                  end else if (r_flush_cnt != 2'd0) begin
                     r_state <= BR_FLUSH;
                  end else begin
                     r_state <= RUN;
                  end
               end else begin
                  r_wait_cnt <= w_wait_inc;
                  if (w_wait_inc == C_MEM_TIMEOUT) r_mem_timeout <= 1'b1;
               end
            end
            default: r_state <= RUN;
         endcase
      end
   end

   assign mem_timeout  = r_mem_timeout;
   assign stall_cycles = r_stall_cycles;
   assign flush_events = r_flush_events;

endmodule : hazard_ctrl
`default_nettype wire
